iir_stream_filter: RTL and testbench
====================================

Name: iir_stream_filter

Overview:
- Streaming IIR low-pass filter: one signed 16-bit sample per clock in, one filtered sample per clock out.
- Output is tagged with its sample index (addr) so a downstream buffer can store the result.
- Two cascaded direct-form-I biquad sections with fixed coefficients.
- Run is armed by start; filter_done is raised once N_SAMPLES outputs have been produced.

Parameters:
- N_SAMPLES, 2048, samples per run; filter_done after this many outputs.
- ADDR_W, 11, width of addr (clog2 N_SAMPLES).
- DATA_W, 16, sample width, signed Q1.15.
- COEF_W, 16, coefficient width, signed Q2.14.
- COEF_FRAC, 14, coefficient fractional bits.
- WARMUP, 0, valid outputs produced before stable_out rises.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  arm a run; level or pulse, acted on while IDLE or DONE
- data_in  in  16  signed input sample
- data_in_valid  in  1  data_in is a sample (accepted only in RUN)
- filter_done  out  1  level, high after N_SAMPLES outputs, until next start or reset
- addr  out  ADDR_W  index of the sample currently on data_out
- data_out  out  16  signed filtered sample
- data_out_valid  out  1  one-cycle qualifier per output sample
- stable_out  out  1  high once WARMUP outputs have been emitted in the current run

Behaviour:
- Reset (async, rst_n=0) clears:
  - all outputs to 0;
  - state machine to IDLE;
  - all filter delay registers (x1, x2, y1, y2 of both sections);
  - input and output counters.
- State IDLE: inputs are ignored. start=1 moves to RUN, clears the delay lines and both counters, and clears filter_done.
- State RUN:
  - Each cycle with data_in_valid=1 accepts one sample. There is no backpressure.
  - Input register stage, then section 1 register stage, then section 2/output register stage.
  - Fixed latency: data_out_valid is asserted exactly 3 cycles after the accepting edge.
  - Output addr counts 0..N_SAMPLES-1 in acceptance order.
  - Gaps in data_in_valid propagate as gaps in data_out_valid. The filter state does not advance on invalid cycles.
- Transition to DONE: on the cycle the output with addr=N_SAMPLES-1 is emitted.
- State DONE:
  - filter_done=1 is held.
  - Further data_in_valid is ignored.
  - start re-arms the run, as from IDLE.
- Counter limit: input samples beyond N_SAMPLES within one run are ignored, and addr never wraps.
- start during RUN is ignored.
- stable_out rises in the same cycle as the WARMUP-th valid output (WARMUP=0 means it rises with addr 0). It is cleared by start or reset.
- Section arithmetic: y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2.
  - Products are full 32-bit; accumulate in 40 bits.
  - Add 2^(COEF_FRAC-1), then arithmetic shift right by COEF_FRAC.
  - Saturate to [-32768, 32767].
  - The saturated y is both the section output and the stored y1.
- Coefficients (Q2.14), identical for both sections:
  - b0=1024, b1=2048, b2=1024 (0.0625, 0.125, 0.0625)
  - a1=-20480 (-1.25), a2=8192 (0.5)
  - DC gain is exactly 1; poles lie at radius 0.707.
- Simultaneous events: start in the same cycle as data_in_valid while in IDLE arms only; that sample is not accepted.

Decomposition:
- Package iir_pkg holds:
  - coefficient constants B0, B1, B2, A1, A2;
  - the Q-format constants;
  - the state enum IDLE/RUN/DONE;
  - a saturate function.
- One sub-module, iir_biquad (DF-I, one register stage, enable input, synchronous clear). It is instantiated twice.
- Top level holds the FSM, the counters and the valid/addr pipeline.

Test Plan:
- Reset check: rst_n low mid-run -> all outputs 0 immediately; after release with no start, data_in_valid is ignored and there is no data_out_valid.
- Impulse: start, then data_in=0x4000 followed by zeros -> addr0=64 (0x0040), addr1=416 (0x01A0); data_out_valid appears 3 cycles after the first accept.
- Step: 2048 samples of 0x1000 -> output settles to 0x1000 ±1 by addr 100; filter_done=1 after the cycle where addr=2047, and stays high.
- Saturation: step of 0x7FFF -> the overshoot clamps at 0x7FFF, never wraps negative; settles to 0x7FFF.
- Gapped input: data_in_valid toggling 1/0 for 20 samples -> output values are identical to the gapless run; addr stays contiguous 0..19.
- Re-run: after filter_done, pulse start and replay the impulse test -> identical outputs; filter_done is cleared on start; addr restarts at 0.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared constants, coefficient set, FSM encoding and saturation helper
// for the two-section streaming IIR low-pass filter.
package iir_pkg;

  localparam int N_SAMPLES = 2048;
  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 16;
  localparam int COEF_W    = 16;
  localparam int COEF_FRAC = 14;
  localparam int WARMUP    = 0;
  localparam int PROD_W    = DATA_W + COEF_W;
  localparam int ACC_W     = 40;

  // Q2.14 coefficients shared by both sections; unity DC gain, poles at r=0.707
  localparam logic signed [COEF_W-1:0] B0 = 16'sd1024;
  localparam logic signed [COEF_W-1:0] B1 = 16'sd2048;
  localparam logic signed [COEF_W-1:0] B2 = 16'sd1024;
  localparam logic signed [COEF_W-1:0] A1 = -16'sd20480;
  localparam logic signed [COEF_W-1:0] A2 = 16'sd8192;

  localparam logic signed [ACC_W-1:0] ROUND_C = ACC_W'(2 ** (COEF_FRAC - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(2 ** (DATA_W - 1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } iir_state_e;

  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    logic signed [DATA_W-1:0] r;
    if (v > SAT_MAX) r = SAT_MAX[DATA_W-1:0];
    else if (v < SAT_MIN) r = SAT_MIN[DATA_W-1:0];
    else r = v[DATA_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/iir_biquad.sv
// Direct-form-I biquad with one register stage; the registered, saturated
// output doubles as the y1 delay element. State only moves when en is high.
module iir_biquad
  import iir_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] x,
  output logic signed [DATA_W-1:0] y
);

  logic signed [DATA_W-1:0] x1_q, x1_d;
  logic signed [DATA_W-1:0] x2_q, x2_d;
  logic signed [DATA_W-1:0] y1_q, y1_d;
  logic signed [DATA_W-1:0] y2_q, y2_d;
  logic signed [PROD_W-1:0] p_b0, p_b1, p_b2, p_a1, p_a2;
  logic signed [ACC_W-1:0]  acc, acc_shr;
  logic signed [DATA_W-1:0] y_sat;

  always_comb begin
    p_b0    = PROD_W'(x) * PROD_W'(B0);
    p_b1    = PROD_W'(x1_q) * PROD_W'(B1);
    p_b2    = PROD_W'(x2_q) * PROD_W'(B2);
    p_a1    = PROD_W'(y1_q) * PROD_W'(A1);
    p_a2    = PROD_W'(y2_q) * PROD_W'(A2);
    acc     = ACC_W'(p_b0) + ACC_W'(p_b1) + ACC_W'(p_b2) - ACC_W'(p_a1) - ACC_W'(p_a2);
    // Round half up, then drop the coefficient fraction bits
    acc_shr = (acc + ROUND_C) >>> COEF_FRAC;
    y_sat   = saturate(acc_shr);
  end

  always_comb begin
    x1_d = x1_q;
    x2_d = x2_q;
    y1_d = y1_q;
    y2_d = y2_q;
    if (clr) begin
      x1_d = '0;
      x2_d = '0;
      y1_d = '0;
      y2_d = '0;
    end else if (en) begin
      x1_d = x;
      x2_d = x1_q;
      y1_d = y_sat;
      y2_d = y1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1_q <= '0;
      x2_q <= '0;
      y1_q <= '0;
      y2_q <= '0;
    end else begin
      x1_q <= x1_d;
      x2_q <= x2_d;
      y1_q <= y1_d;
      y2_q <= y2_d;
    end
  end

  assign y = y1_q;

endmodule

// File: rtl/iir_stream_filter.sv
// Streaming two-section IIR low-pass: input register, biquad 1, biquad 2.
// Output is tagged with its sample index; filter_done after N_SAMPLES outputs.
module iir_stream_filter
  import iir_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     data_in_valid,
  output logic                     filter_done,
  output logic [ADDR_W-1:0]        addr,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     data_out_valid,
  output logic                     stable_out
);

  localparam logic [ADDR_W:0]   IN_LIMIT    = (ADDR_W + 1)'(N_SAMPLES);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(N_SAMPLES - 1);
  localparam logic [ADDR_W-1:0] STABLE_ADDR = ADDR_W'((WARMUP == 0) ? 0 : WARMUP - 1);

  iir_state_e state_q, state_d;
  logic run_en, arm, accept, last_out;
  logic [ADDR_W:0] in_cnt_q, in_cnt_d;
  logic signed [DATA_W-1:0] x0_q, x0_d;
  logic v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
  logic [ADDR_W-1:0] a0_q, a0_d, a1_q, a1_d, a2_q, a2_d;
  logic stable_q, stable_d;
  logic signed [DATA_W-1:0] s1_y, s2_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_out) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    run_en      = (state_q == RUN);
    arm         = start && (state_q != RUN);
    filter_done = (state_q == DONE);
  end

  // Valid and index travel alongside the samples so gaps stay gaps
  always_comb begin
    accept   = run_en && data_in_valid && (in_cnt_q < IN_LIMIT);
    last_out = v1_q && (a1_q == LAST_ADDR);
    in_cnt_d = in_cnt_q;
    x0_d     = x0_q;
    a0_d     = a0_q;
    a1_d     = a1_q;
    a2_d     = a2_q;
    v0_d     = accept;
    v1_d     = v0_q;
    v2_d     = v1_q;
    stable_d = stable_q;
    if (accept) begin
      x0_d     = data_in;
      a0_d     = in_cnt_q[ADDR_W-1:0];
      in_cnt_d = in_cnt_q + (ADDR_W + 1)'(1);
    end
    if (v0_q) a1_d = a0_q;
    if (v1_q) begin
      a2_d = a1_q;
      if (a1_q == STABLE_ADDR) stable_d = 1'b1;
    end
    if (arm) begin
      in_cnt_d = '0;
      a0_d     = '0;
      a1_d     = '0;
      a2_d     = '0;
      v0_d     = 1'b0;
      v1_d     = 1'b0;
      v2_d     = 1'b0;
      stable_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt_q <= '0;
      x0_q     <= '0;
      v0_q     <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      a0_q     <= '0;
      a1_q     <= '0;
      a2_q     <= '0;
      stable_q <= 1'b0;
    end else begin
      in_cnt_q <= in_cnt_d;
      x0_q     <= x0_d;
      v0_q     <= v0_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      a0_q     <= a0_d;
      a1_q     <= a1_d;
      a2_q     <= a2_d;
      stable_q <= stable_d;
    end
  end

  iir_biquad u_sec1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (v0_q),
    .clr   (arm),
    .x     (x0_q),
    .y     (s1_y)
  );

  iir_biquad u_sec2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (v1_q),
    .clr   (arm),
    .x     (s1_y),
    .y     (s2_y)
  );

  assign data_out       = s2_y;
  assign data_out_valid = v2_q;
  assign addr           = a2_q;
  assign stable_out     = stable_q;

endmodule

// File: tb/tb_iir_stream_filter.sv
// Bench for iir_stream_filter: directed runs (impulse, step, saturation,
// gapped input, re-arm, reset) checked through an expected-output queue.
module tb_iir_stream_filter;

  localparam int N = 2048;

  typedef struct {
    int addr;
    int lo;
    int hi;
    int cyc;
    bit chk;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               start = 1'b0;
  logic signed [15:0] data_in = '0;
  logic               data_in_valid = 1'b0;
  logic               filter_done;
  logic [10:0]        addr;
  logic signed [15:0] data_out;
  logic               data_out_valid;
  logic               stable_out;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  int   out_seen = 0;

  iir_stream_filter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .filter_done    (filter_done),
    .addr           (addr),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .stable_out     (stable_out)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  // impulse response of 0x4000 through both sections, worked by hand
  function automatic int imp_val(input int i);
    case (i)
      0:       return 64;
      1:       return 416;
      2:       return 1260;
      3:       return 2420;
      4:       return 3389;
      default: return 0;
    endcase
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (data_out_valid) begin
      out_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("addr", int'(addr), mon_e.addr, mon_e.addr);
        check("latency_cycle", cyc, mon_e.cyc, mon_e.cyc);
        if (mon_e.chk) check("data_out", int'(data_out), mon_e.lo, mon_e.hi);
        check("stable_out_high", int'(stable_out), 1, 1);
        if (mon_e.addr < N - 1) check("filter_done_early", int'(filter_done), 0, 0);
      end
    end
  end

  // drivers
  task automatic drive(input logic signed [15:0] d, input logic v, input int a,
                       input int lo, input int hi, input bit chk);
    exp_t e;
    @(posedge clk); #1;
    start         = 1'b0;
    data_in       = d;
    data_in_valid = v;
    if (v && a >= 0) begin
      e.addr = a;
      e.lo   = lo;
      e.hi   = hi;
      e.cyc  = cyc + 3;
      e.chk  = chk;
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic with_valid);
    @(posedge clk); #1;
    start         = 1'b1;
    data_in       = 16'sh7777;
    data_in_valid = with_valid;
    @(posedge clk); #1;
    start         = 1'b0;
    data_in_valid = 1'b0;
    check("done_cleared_on_start", int'(filter_done), 0, 0);
    check("stable_cleared_on_start", int'(stable_out), 0, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    if (exp_q.size() > 0) begin
      check("drain_timeout", exp_q.size(), 0, 0);
      exp_q.delete();
    end
  endtask

  task automatic idle_ignore(input string name);
    int seen;
    seen = out_seen;
    repeat (5) drive(16'sh4000, 1'b1, -1, 0, 0, 1'b0);
    repeat (6) drive(16'sh0000, 1'b0, -1, 0, 0, 1'b0);
    check(name, out_seen, seen, seen);
  endtask

  task automatic run_full(input int kind);
    for (int i = 0; i < N; i++) begin
      logic signed [15:0] x;
      int lo, hi;
      bit chk;
      lo = 0; hi = 0; chk = 1'b1;
      case (kind)
        0: begin
          x = (i == 0) ? 16'sh4000 : 16'sh0000;
          if (i < 5) begin lo = imp_val(i); hi = lo; end
          else chk = 1'b0;
        end
        1: begin
          x = 16'sh1000;
          if (i == 0)      begin lo = 16;   hi = 16;    end
          else if (i < 100) begin lo = 0;    hi = 32767; end
          else             begin lo = 4094; hi = 4098;  end
        end
        default: begin
          x = 16'sh7fff;
          if (i == 0)      begin lo = 128;   hi = 128;   end
          else if (i < 100) begin lo = 0;     hi = 32767; end
          else             begin lo = 32765; hi = 32767; end
        end
      endcase
      drive(x, 1'b1, i, lo, hi, chk);
    end
    drive(16'sh0000, 1'b0, -1, 0, 0, 1'b0);
    drain();
  endtask

  task automatic check_done_hold();
    int seen;
    check("filter_done_set", int'(filter_done), 1, 1);
    seen = out_seen;
    repeat (4) drive(16'sh4000, 1'b1, -1, 0, 0, 1'b0);
    repeat (5) drive(16'sh0000, 1'b0, -1, 0, 0, 1'b0);
    check("done_ignores_input", out_seen, seen, seen);
    check("filter_done_hold", int'(filter_done), 1, 1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("reset_addr", int'(addr), 0, 0);
    check("reset_data_out", int'(data_out), 0, 0);
    check("reset_valid", int'(data_out_valid), 0, 0);
    check("reset_done", int'(filter_done), 0, 0);
    check("reset_stable", int'(stable_out), 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    idle_ignore("idle_ignores_input");

    // start together with a valid sample: arms only
    pulse_start(1'b1);
    run_full(0);
    check_done_hold();

    // re-arm from DONE and replay the impulse
    pulse_start(1'b0);
    run_full(0);
    check_done_hold();

    pulse_start(1'b0);
    run_full(1);
    check_done_hold();

    pulse_start(1'b0);
    run_full(2);
    check_done_hold();

    // gapped impulse: every other cycle invalid with junk data
    pulse_start(1'b0);
    for (int i = 0; i < 20; i++) begin
      if (i < 5) drive((i == 0) ? 16'sh4000 : 16'sh0000, 1'b1, i, imp_val(i), imp_val(i), 1'b1);
      else       drive(16'sh0000, 1'b1, i, 0, 0, 1'b0);
      drive(16'sh1234, 1'b0, -1, 0, 0, 1'b0);
    end
    drain();
    check("gapped_not_done", int'(filter_done), 0, 0);

    // asynchronous reset mid-run with samples in flight
    drive(16'sh4000, 1'b1, -1, 0, 0, 1'b0);
    drive(16'sh4000, 1'b1, -1, 0, 0, 1'b0);
    @(posedge clk); #2;
    rst_n         = 1'b0;
    data_in_valid = 1'b0;
    #1;
    check("midrun_reset_addr", int'(addr), 0, 0);
    check("midrun_reset_data_out", int'(data_out), 0, 0);
    check("midrun_reset_valid", int'(data_out_valid), 0, 0);
    check("midrun_reset_done", int'(filter_done), 0, 0);
    check("midrun_reset_stable", int'(stable_out), 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_ignore("post_reset_ignores_input");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
